// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op encodings and sequencer state encodings shared by
// control decode, the hazard unit and the MDU itself.
package mdu_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E/D-stage request side and HI/LO/hazard result side of the MDU.
interface mdu_if;
   logic [3:0]  md_op_E;
   logic [31:0] A_E;
   logic [31:0] B_E;
   logic        md_use_D;
   logic [31:0] md_rd_E;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_md;

   modport master (output md_op_E, A_E, B_E, md_use_D,
                   input  md_rd_E, hi, lo, busy, stall_md);
   modport slave  (input  md_op_E, A_E, B_E, md_use_D,
                   output md_rd_E, hi, lo, busy, stall_md);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply / divide producing {res_hi,res_lo}.
// Division by zero yields a don't-care result (the sequencer discards it).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        bdiv, mag_a, mag_b, qm, rm, q_u, r_u, q_s, r_s;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // substitute 1 for a zero divisor so the divider never sees /0
   assign bdiv  = (b == 32'd0) ? 32'd1 : b;
   assign q_u   = a / bdiv;
   assign r_u   = a % bdiv;

   // signed divide on magnitudes: quotient truncates toward zero and the
   // remainder follows the dividend; 0x80000000/-1 wraps back to 0x80000000
   assign mag_a = a[31]    ? (~a + 32'd1)    : a;
   assign mag_b = bdiv[31] ? (~bdiv + 32'd1) : bdiv;
   assign qm    = mag_a / mag_b;
   assign rm    = mag_a % mag_b;
   assign q_s   = (a[31] ^ bdiv[31]) ? (~qm + 32'd1) : qm;
   assign r_s   = a[31] ? (~rm + 32'd1) : rm;

   // result select by op
   always_comb begin
      {res_hi, res_lo} = 64'd0;
      case (op)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         MD_DIV:   {res_hi, res_lo} = {r_s, q_s};
         MD_DIVU:  {res_hi, res_lo} = {r_u, q_u};
         default:  {res_hi, res_lo} = 64'd0;
      endcase
   end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer. Owns HI/LO, models fixed MDU latency
// with a down-counter and raises a D-stage stall for dependent MDU ops.
// Optional: MDU_EARLY_OUT_EN shortens zero-operand mult and div-by-zero to 1 cycle.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
)(
   input  logic clk,
   input  logic reset,
   mdu_if.slave mdu
);
   localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW     = $clog2(MAXLAT + 1);

   md_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, lat;
   logic        busy_q, busy_d, commit;
   logic [31:0] hi_q, lo_q, tmp_hi, tmp_lo, res_hi, res_lo;
   logic        tmp_wr;
   logic        is_mul, is_div, start, early;

   mdu_arith u_arith (
      .op     (mdu.md_op_E),
      .a      (mdu.A_E),
      .b      (mdu.B_E),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   assign is_mul = (mdu.md_op_E == MD_MULT) || (mdu.md_op_E == MD_MULTU);
   assign is_div = (mdu.md_op_E == MD_DIV)  || (mdu.md_op_E == MD_DIVU);
   assign start  = (state_q == ST_IDLE) && (is_mul || is_div);

`ifdef MDU_EARLY_OUT_EN
   assign early = (is_mul && (mdu.A_E == 32'd0 || mdu.B_E == 32'd0)) ||
                  (is_div && (mdu.B_E == 32'd0));
`else
   assign early = 1'b0;
`endif

   assign lat = early  ? CW'(1) :
                is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);

   // next-state, counter and busy decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = lat;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               commit  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // counter, busy, pending result and architectural HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         tmp_hi <= '0;
         tmp_lo <= '0;
         tmp_wr <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         if (start) begin
            tmp_hi <= res_hi;
            tmp_lo <= res_lo;
            // divide by zero leaves HI/LO untouched at completion
            tmp_wr <= !(is_div && mdu.B_E == 32'd0);
         end
         if (commit) begin
            if (tmp_wr) begin
               hi_q <= tmp_hi;
               lo_q <= tmp_lo;
            end
         end else if (state_q == ST_IDLE) begin
            if (mdu.md_op_E == MD_MTHI) hi_q <= mdu.A_E;
            if (mdu.md_op_E == MD_MTLO) lo_q <= mdu.A_E;
         end
      end
   end

   assign mdu.hi       = hi_q;
   assign mdu.lo       = lo_q;
   assign mdu.busy     = busy_q;
   assign mdu.stall_md = mdu.md_use_D && (start || busy_q);
   assign mdu.md_rd_E  = (mdu.md_op_E == MD_MFHI) ? hi_q :
                         (mdu.md_op_E == MD_MFLO) ? lo_q : 32'd0;
endmodule
